wb_drain_ctrl: RTL and testbench
================================

Name: wb_drain_ctrl

Overview:
- Sequencer between the store write-buffer FIFO and the AXI write channels.
- Takes the oldest entry from the FIFO's read port and issues one single-beat AXI write (AW, W, B).
- Pops the entry only after the write response has been accepted.
- Reports when the buffer is fully drained, so uncached loads and cache misses can be ordered after earlier stores.

Parameters:
- DATA_WIDTH, 71, FIFO entry width. Packing: [70:68] size, [67:64] strb, [63:32] addr, [31:0] data.
- AXI_ID, 1, value driven on awid and wid.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- fifo_rdata  input  DATA_WIDTH  head entry from the FIFO (zero when empty)
- fifo_empty  input  1  FIFO has no entries
- fifo_complete  output  1  one-cycle pop strobe to the FIFO
- hold  input  1  blocks the start of a new transaction
- drain_idle  output  1  FIFO empty and no transaction in flight
- awid  output  4  fixed AXI_ID
- awaddr  output  32  write address
- awlen  output  8  fixed 0
- awsize  output  3  entry size
- awburst  output  2  fixed 2'b01
- awvalid  output  1  address valid
- awready  input  1  address accepted
- wid  output  4  fixed AXI_ID
- wdata  output  32  write data
- wstrb  output  4  byte strobes
- wlast  output  1  fixed 1
- wvalid  output  1  data valid
- wready  input  1  data accepted
- bvalid  input  1  response valid
- bresp  input  2  response code
- bready  output  1  response accept
- bus_err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (resetn=0 at a clk edge) has priority over all other activity and applies mid-transaction:
  - state becomes IDLE.
  - awvalid, wvalid, bready, fifo_complete and bus_err go to 0.
  - awaddr, wdata, wstrb and awsize registers are cleared to 0.
- States: IDLE, REQ, RESP, POP.
- IDLE:
  - If !fifo_empty && !hold, capture addr/data/strb/size from fifo_rdata into registers.
  - Set awvalid=1 and wvalid=1 together, then go to REQ.
  - Latency from a non-empty FIFO to awvalid is 1 cycle.
- REQ:
  - Two internal flags, aw_done and w_done, track the two handshakes independently.
  - awvalid drops the cycle after awvalid&&awready; wvalid drops the cycle after wvalid&&wready.
  - Handshakes may complete in the same cycle or in any order.
  - Once both are done (including same-cycle completion), go to RESP with bready=1.
  - The captured outputs stay stable while their valid is high, per AXI.
- RESP:
  - bready=1.
  - On bvalid, go to POP and drop bready.
  - If bvalid is already high on entry, it is accepted in that first RESP cycle.
- POP:
  - fifo_complete=1 for exactly one cycle, then return to IDLE.
  - The next entry can start no earlier than the cycle after POP; one transaction is outstanding at a time.
- Entry payload:
  - The entry is never re-read while in flight.
  - FIFO writes during a transaction do not affect the payload (it is registered).
- hold:
  - Sampled only in IDLE.
  - Asserting hold in REQ/RESP/POP does not abort the transaction.
- drain_idle:
  - Combinational: (state==IDLE) && fifo_empty.
  - Reset value 1 when the FIFO is empty.
- Fixed fields: awlen=0, awburst=01, wlast=1, awid=wid=AXI_ID at all times.
- No retry on an error response; the entry is popped regardless of bresp.

Optional Feature:
- Macro: WB_BRESP_ERR_EN.
- With the macro defined:
  - bus_err is set on the RESP-state bvalid handshake when bresp is 2'b10 or 2'b11.
  - It stays set until reset.
- Without the macro: bus_err is tied to 0 and bresp is ignored.

Test Plan:
- Reset with FIFO empty:
  - awvalid=wvalid=bready=fifo_complete=0 and drain_idle=1.
  - Releasing resetn with fifo_empty=1 keeps all of these for 10 cycles.
- Single entry addr=0x1FC0_0010, data=0xDEADBEEF, strb=4'hF, size=2 with awready=wready=bvalid=1 constant:
  - awvalid/wvalid high 1 cycle after resetn, then RESP, then POP.
  - Exactly one fifo_complete pulse; drain_idle returns to 1 once the FIFO reports empty.
- Skewed handshakes:
  - wready asserted 3 cycles before awready.
  - wvalid drops first; bready asserts only after the AW handshake.
  - awaddr is unchanged across all stall cycles.
- Back-to-back entries A=0x100, B=0x104 with bvalid delayed 5 cycles each:
  - Exactly two AW transactions in order 0x100 then 0x104, with no overlap.
  - Two fifo_complete pulses.
- hold=1 with FIFO non-empty:
  - No awvalid for 8 cycles.
  - Deassert hold, and awvalid rises the next cycle.
  - Assert hold mid-REQ, and the transaction still completes.
- Error response bresp=2'b10 on one entry, then reset mid-REQ on the next entry:
  - With WB_BRESP_ERR_EN, bus_err=1 after the first entry's B handshake.
  - The entry is still popped.
  - The reset mid-REQ clears bus_err and forces awvalid=0 the following cycle.
  - Without the macro, bus_err stays 0.

Source files
------------

// File: rtl/wb_drain_ctrl.sv
// wb_drain_ctrl: drains the store write-buffer FIFO onto the AXI write channels.
// Takes the FIFO head entry, issues one single-beat AXI write (AW + W, then B),
// and pops the entry only after the write response has been accepted. Only one
// transaction is outstanding at a time. drain_idle tells the load/miss path that
// all earlier stores have completed.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   fifo_rdata         head entry {size[70:68], strb[67:64], addr[63:32], data[31:0]}
//   fifo_empty         FIFO has no entries
//   fifo_complete      one-cycle pop strobe back to the FIFO
//   hold               blocks the start of a new transaction (sampled in IDLE only)
//   drain_idle         combinational: IDLE and FIFO empty
//   aw*/w*/b*          AXI3-style write address / data / response channels
//   bus_err            sticky error-response flag
//
// Build option: define WB_BRESP_ERR_EN to make bus_err latch SLVERR/DECERR
// responses; otherwise bus_err is tied low and bresp is ignored.

module wb_drain_ctrl #(
  parameter int unsigned DATA_WIDTH = 71,
  parameter logic [3:0]  AXI_ID     = 4'd1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  fifo_complete,
  input  logic                  hold,
  output logic                  drain_idle,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic                  bus_err
);

  // Field positions inside a FIFO entry
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned STRB_LSB = 64;
  localparam int unsigned SIZE_LSB = 68;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    POP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        complete_q, complete_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  size_q, size_d;

  logic aw_hs, w_hs, b_hs;

  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;
  assign b_hs  = bready_q && bvalid;

  // State and output registers; reset wins over everything, including mid-transaction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      complete_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      strb_q     <= 4'd0;
      size_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      complete_q <= complete_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      size_q     <= size_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    complete_d = 1'b0;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    size_d     = size_q;

    case (state_q)
      IDLE: begin
        // Payload is registered once here so later FIFO writes cannot disturb it
        if (!fifo_empty && !hold) begin
          data_d    = fifo_rdata[DATA_LSB +: 32];
          addr_d    = fifo_rdata[ADDR_LSB +: 32];
          strb_d    = fifo_rdata[STRB_LSB +: 4];
          size_d    = fifo_rdata[SIZE_LSB +: 3];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = REQ;
        end
      end

      REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Either channel may finish first, or both in the same cycle
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end

      RESP: begin
        bready_d = 1'b1;
        if (b_hs) begin
          bready_d   = 1'b0;
          complete_d = 1'b1;
          state_d    = POP;
        end
      end

      POP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef WB_BRESP_ERR_EN
  logic bus_err_q, bus_err_d;

  // Sticky on SLVERR/DECERR (bresp[1] set); only reset clears it
  assign bus_err_d = bus_err_q || ((state_q == RESP) && b_hs && bresp[1]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign bus_err      = 1'b0;
`endif

  assign drain_idle    = (state_q == IDLE) && fifo_empty;
  assign fifo_complete = complete_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;

  assign wid     = AXI_ID;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

  assign bready  = bready_q;

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Bench for wb_drain_ctrl: a ring-buffer FIFO model, an AXI write slave with
// per-channel latencies, and a scoreboard of expected AW/W payloads pushed when
// entries enter the FIFO and popped at each handshake. The slave, monitor and
// stimulus all run in one process: slave/monitor work at the falling edge,
// stimulus and direct checks one time unit after the rising edge.

module tb_wb_drain_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  size;
    int          aw_lat;
    int          w_lat;
    int          b_lat;
    logic [31:0] exp_awaddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [2:0]  exp_awsize;
  } vec_t;

`ifdef WB_BRESP_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [70:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_complete;
  logic        hold;
  logic        drain_idle;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;
  logic        bus_err;

  always #5 clk = ~clk;

  wb_drain_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .fifo_rdata    (fifo_rdata),
    .fifo_empty    (fifo_empty),
    .fifo_complete (fifo_complete),
    .hold          (hold),
    .drain_idle    (drain_idle),
    .awid          (awid),
    .awaddr        (awaddr),
    .awlen         (awlen),
    .awsize        (awsize),
    .awburst       (awburst),
    .awvalid       (awvalid),
    .awready       (awready),
    .wid           (wid),
    .wdata         (wdata),
    .wstrb         (wstrb),
    .wlast         (wlast),
    .wvalid        (wvalid),
    .wready        (wready),
    .bvalid        (bvalid),
    .bresp         (bresp),
    .bready        (bready),
    .bus_err       (bus_err)
  );

  // FIFO model
  logic [70:0] fifo_mem [16];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = fifo_empty ? 71'd0 : fifo_mem[rd_ptr];

  // Scoreboard and slave state
  exp_t        exp_aw_q[$];
  exp_t        exp_w_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  int          pops_exp = 0;
  int          aw_lat = 0, w_lat = 0, b_lat = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic        const_mode = 1'b0;
  logic [1:0]  resp_code = 2'b00;
  logic        aw_seen = 1'b0, w_seen = 1'b0, b_done = 1'b0, prev_fc = 1'b0;
  logic        prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic [2:0]  prev_awsize = '0;
  logic [3:0]  prev_wstrb = '0;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_entry(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] sz);
    exp_t e;
    e.addr = a; e.data = d; e.strb = s; e.size = sz;
    fifo_mem[wr_ptr] = {sz, s, a, d};
    wr_ptr = wr_ptr + 4'd1;
    exp_aw_q.push_back(e);
    exp_w_q.push_back(e);
    pops_exp++;
  endtask

  // AXI slave + protocol monitor, evaluated while DUT outputs are stable
  task automatic slave_step();
    exp_t e;
    if (!resetn) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      aw_seen = 1'b0; w_seen = 1'b0; b_done = 1'b0; prev_fc = 1'b0;
      prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
    end else begin
      if (prev_aw_stall)
        check("aw_stable", 64'({awvalid, awsize, awaddr}), 64'({1'b1, prev_awsize, prev_awaddr}));
      if (prev_w_stall)
        check("w_stable", 64'({wvalid, wstrb, wdata}), 64'({1'b1, prev_wstrb, prev_wdata}));
      if (bready)
        check("bready_after_aw_w", 64'({aw_seen, w_seen}), 64'(2'b11));
      if (fifo_complete) begin
        check("pop_after_b_single", 64'({b_done, prev_fc}), 64'(2'b10));
        b_done = 1'b0;
        rd_ptr = rd_ptr + 4'd1;
        n_pops++;
      end
      prev_fc = fifo_complete;

      if (const_mode) begin
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      end else begin
        awready = awvalid && (aw_cnt >= aw_lat);
        if (awvalid && !awready) aw_cnt++;
        wready = wvalid && (w_cnt >= w_lat);
        if (wvalid && !wready) w_cnt++;
        bvalid = aw_seen && w_seen && (b_cnt >= b_lat);
        if (aw_seen && w_seen && !bvalid) b_cnt++;
      end
      bresp = resp_code;

      if (awvalid && awready) begin
        check("aw_no_overlap", 64'({aw_seen, b_done}), 64'(2'b00));
        if (exp_aw_q.size() == 0) begin
          check("aw_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_aw_q.pop_front();
          check("awaddr", 64'(awaddr), 64'(e.addr));
          check("awsize", 64'(awsize), 64'(e.size));
          check("aw_fixed", 64'({awlen, awburst, awid}), 64'({8'd0, 2'b01, 4'd1}));
        end
        aw_seen = 1'b1;
        aw_cnt  = 0;
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) begin
          check("w_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_w_q.pop_front();
          check("wdata_wstrb", 64'({wstrb, wdata}), 64'({e.strb, e.data}));
          check("w_fixed", 64'({wlast, wid}), 64'({1'b1, 4'd1}));
        end
        w_seen = 1'b1;
        w_cnt  = 0;
      end
      if (bvalid && bready) begin
        check("b_order", 64'({aw_seen, w_seen}), 64'(2'b11));
        aw_seen = 1'b0; w_seen = 1'b0; b_cnt = 0;
        b_done  = 1'b1;
      end

      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
      prev_awsize   = awsize;
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      prev_wstrb    = wstrb;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int budget);
    for (int i = 0; i < budget && n_pops < pops_exp; i++) tick();
    check("pop_count", 64'(n_pops), 64'(pops_exp));
  endtask

  initial begin
    resetn = 1'b0; hold = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;

    vecs[0] = '{32'h0000_1000, 32'h1122_3344, 4'hF, 3'd2, 0, 0, 0, 32'h0000_1000, 32'h1122_3344, 4'hF, 3'd2};
    vecs[1] = '{32'h0000_2001, 32'h0000_00A5, 4'h2, 3'd0, 2, 0, 1, 32'h0000_2001, 32'h0000_00A5, 4'h2, 3'd0};
    vecs[2] = '{32'h8000_0002, 32'hBEEF_0000, 4'hC, 3'd1, 0, 4, 3, 32'h8000_0002, 32'hBEEF_0000, 4'hC, 3'd1};
    vecs[3] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 3'd2, 3, 3, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 3'd2};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 4'h0, 3'd2, 1, 2, 6, 32'h0000_0000, 32'h0000_0000, 4'h0, 3'd2};

    @(posedge clk); #1;
    tick(); tick();

    // Reset with the FIFO empty, then 10 quiet cycles after release
    check("reset_state", 64'({awvalid, wvalid, bready, fifo_complete, drain_idle, bus_err}), 64'(6'b000010));
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_after_reset", 64'({awvalid, wvalid, bready, fifo_complete, drain_idle}), 64'(5'b00001));
    end

    // Single entry, all slave signals held high
    resetn = 1'b0;
    const_mode = 1'b1;
    push_entry(32'h1FC0_0010, 32'hDEAD_BEEF, 4'hF, 3'd2);
    tick();
    check("drain_idle_busy_fifo", 64'(drain_idle), 64'(0));
    resetn = 1'b1;
    tick();
    check("single_valid", 64'({awvalid, wvalid, bready}), 64'(3'b110));
    tick();
    check("single_resp", 64'({awvalid, wvalid, bready, fifo_complete}), 64'(4'b0010));
    tick();
    check("single_pop", 64'({bready, fifo_complete, drain_idle}), 64'(3'b010));
    tick();
    check("single_done", 64'({fifo_complete, drain_idle}), 64'(2'b01));
    check("single_pop_count", 64'(n_pops), 64'(1));
    const_mode = 1'b0;

    // Skewed handshakes: W accepted 3 cycles before AW
    aw_lat = 3; w_lat = 0; b_lat = 0;
    push_entry(32'h0000_0040, 32'hCAFE_F00D, 4'h3, 3'd1);
    tick();
    check("skew_valid", 64'({awvalid, wvalid, bready}), 64'(3'b110));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("skew_stall", 64'({awvalid, wvalid, bready}), 64'(3'b100));
      check("skew_awaddr", 64'(awaddr), 64'(32'h0000_0040));
    end
    tick();
    check("skew_resp", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    wait_pops(20);

    // Table-driven entries with assorted latencies
    for (int v = 0; v < 5; v++) begin
      aw_lat = vecs[v].aw_lat; w_lat = vecs[v].w_lat; b_lat = vecs[v].b_lat;
      push_entry(vecs[v].exp_awaddr, vecs[v].exp_wdata, vecs[v].exp_wstrb, vecs[v].exp_awsize);
      check("vec_payload_pack", 64'({vecs[v].size, vecs[v].strb}), 64'({vecs[v].exp_awsize, vecs[v].exp_wstrb}));
      wait_pops(40);
      check("vec_drained", 64'(drain_idle), 64'(1));
    end

    // Back-to-back entries with slow responses
    aw_lat = 0; w_lat = 0; b_lat = 5;
    push_entry(32'h0000_0100, 32'hAAAA_0001, 4'hF, 3'd2);
    push_entry(32'h0000_0104, 32'hBBBB_0002, 4'hF, 3'd2);
    wait_pops(60);
    check("b2b_sb_empty", 64'(exp_aw_q.size() + exp_w_q.size()), 64'(0));

    // hold blocks issue while the FIFO is non-empty
    b_lat = 0;
    hold = 1'b1;
    push_entry(32'h0000_0200, 32'h5555_AAAA, 4'hF, 3'd2);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("hold_blocks", 64'({awvalid, wvalid, drain_idle}), 64'(3'b000));
    end
    aw_lat = 4; w_lat = 2;
    hold = 1'b0;
    tick();
    check("hold_release", 64'({awvalid, wvalid}), 64'(2'b11));
    tick();
    hold = 1'b1;
    wait_pops(30);
    tick();
    check("hold_mid_req_done", 64'({awvalid, drain_idle}), 64'(2'b01));
    hold = 1'b0;

    // Error response, then reset in the middle of the next request
    aw_lat = 0; w_lat = 0; b_lat = 1;
    resp_code = 2'b10;
    push_entry(32'h0000_0300, 32'h0BAD_0BAD, 4'hF, 3'd2);
    wait_pops(20);
    check("bus_err_after_slverr", 64'(bus_err), 64'(EXP_ERR));
    resp_code = 2'b00;
    aw_lat = 20; w_lat = 20;
    push_entry(32'h0000_0304, 32'h600D_600D, 4'hF, 3'd2);
    tick(); tick();
    check("req_before_reset", 64'({awvalid, wvalid}), 64'(2'b11));
    resetn = 1'b0;
    tick();
    check("mid_req_reset", 64'({awvalid, wvalid, bready, fifo_complete, bus_err}), 64'(5'b00000));
    resetn = 1'b1;
    aw_lat = 0; w_lat = 0; b_lat = 0;
    wait_pops(20);
    tick();
    check("final_idle", 64'({drain_idle, fifo_empty, bus_err}), 64'(3'b110));
    check("final_sb_empty", 64'(exp_aw_q.size() + exp_w_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
